// File: rtl/quad_direction_decoder.sv
// quad_direction_decoder: quadrature pair to direction, position, step strobe
// and sticky error, with input sync, glitch filter, still timeout, wrap/clamp.
module quad_direction_decoder #(
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int STILL_TIMEOUT = 1024,
  parameter bit SATURATE      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor1_data,
  input  logic             sensor2_data,
  input  logic             clear,
  output logic [1:0]       direction,
  output logic [CNT_W-1:0] position,
  output logic             step_valid,
  output logic             error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(STILL_TIMEOUT + 1);

  localparam logic [1:0] DIR_CCW   = 2'b00;
  localparam logic [1:0] DIR_STILL = 2'b01;
  localparam logic [1:0] DIR_ERR   = 2'b10;
  localparam logic [1:0] DIR_CW    = 2'b11;

  localparam logic [CNT_W-1:0] POS_MAX =
    {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] POS_MIN =
    {1'b1, {(CNT_W-1){1'b0}}};

  localparam logic [FW-1:0] FILT_END = FW'(FILTER_LEN);
  localparam logic [IW-1:0] IDLE_END = IW'(STILL_TIMEOUT);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  logic [SYNC_STAGES-1:0] sync1;
  logic [SYNC_STAGES-1:0] sync2;
  logic [1:0]             s;
  logic [1:0]             cand;
  logic [1:0]             acc;
  logic [FW-1:0]          fcnt;
  logic [FW-1:0]          fcnt_nx;
  logic                   acc_vld;
  logic                   acc_stb;
  logic                   accept;

  state_t                 state;
  state_t                 state_nx;
  logic [1:0]             ref_q;
  logic [1:0]             ref_nx;
  logic [1:0]             dir_nx;
  logic [CNT_W-1:0]       pos_nx;
  logic                   sv_nx;
  logic                   err_nx;
  logic [IW-1:0]          idle;
  logic [IW-1:0]          idle_nx;
  logic [1:0]             br;
  logic [1:0]             bn;
  logic [1:0]             delta;

  assign s = {sync2[SYNC_STAGES-1], sync1[SYNC_STAGES-1]};

  // Shift each raw sensor through its synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], sensor1_data};
      sync2 <= {sync2[SYNC_STAGES-2:0], sensor2_data};
    end
  end

  // Run length of the current synchronised value, capped at FILTER_LEN
  assign fcnt_nx = (s != cand)         ? FW'(1) :
                   (fcnt == FILT_END)  ? fcnt   :
                                         fcnt + FW'(1);

  assign accept = (fcnt_nx == FILT_END) &&
                  (!acc_vld || (s != acc));

  // Glitch filter: accept a new pair after FILTER_LEN stable cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand    <= '0;
      fcnt    <= '0;
      acc     <= '0;
      acc_vld <= 1'b0;
      acc_stb <= 1'b0;
    end else begin
      cand    <= s;
      fcnt    <= fcnt_nx;
      acc_stb <= accept;
      if (accept) begin
        acc     <= s;
        acc_vld <= 1'b1;
      end
    end
  end

  // Gray code to ring index; delta 1 is clockwise, 3 anticlockwise
  assign br    = {ref_q[1], ref_q[1] ^ ref_q[0]};
  assign bn    = {acc[1], acc[1] ^ acc[0]};
  assign delta = bn - br;

  // Next state and next registered outputs
  always_comb begin
    state_nx = state;
    ref_nx   = ref_q;
    dir_nx   = direction;
    pos_nx   = position;
    sv_nx    = 1'b0;
    err_nx   = error;
    idle_nx  = idle;
    unique case (state)
      INIT: begin
        if (acc_stb) begin
          ref_nx   = acc;
          dir_nx   = DIR_STILL;
          idle_nx  = '0;
          state_nx = TRACK;
        end
      end
      TRACK: begin
        if (acc_stb) begin
          ref_nx  = acc;
          idle_nx = '0;
          unique case (1'b1)
            (delta == 2'd1): begin
              dir_nx = DIR_CW;
              sv_nx  = 1'b1;
              if (!(SATURATE && position == POS_MAX))
                pos_nx = position + CNT_W'(1);
            end
            (delta == 2'd3): begin
              dir_nx = DIR_CCW;
              sv_nx  = 1'b1;
              if (!(SATURATE && position == POS_MIN))
                pos_nx = position - CNT_W'(1);
            end
            default: begin
              dir_nx = DIR_ERR;
              err_nx = 1'b1;
            end
          endcase
        end else begin
          if (idle != IDLE_END)
            idle_nx = idle + IW'(1);
          if (idle_nx == IDLE_END)
            dir_nx = DIR_STILL;
        end
      end
      default: state_nx = INIT;
    endcase
    if (clear) begin
      pos_nx = '0;
      err_nx = 1'b0;
    end
  end

  // State, reference and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      ref_q      <= '0;
      direction  <= DIR_ERR;
      position   <= '0;
      step_valid <= 1'b0;
      error      <= 1'b0;
      idle       <= '0;
    end else begin
      state      <= state_nx;
      ref_q      <= ref_nx;
      direction  <= dir_nx;
      position   <= pos_nx;
      step_valid <= sv_nx;
      error      <= err_nx;
      idle       <= idle_nx;
    end
  end

endmodule

// File: doc/quad_direction_decoder.md
Name: quad_direction_decoder

Overview:
- Parametrised successor to the two-sensor disk direction detector.
- Decodes a 2-bit quadrature pair {sensor2_data, sensor1_data} into a direction code, a signed position count, a per-step strobe and a sticky error flag.
- Adds input synchronisation, a glitch filter, a configurable still-timeout and a wrap/saturate counter mode.
- Sits between the raw disk sensors and the motion-control/readout logic.

Parameters:
- CNT_W, 16: width of the signed position counter, in bits (≥2).
- SYNC_STAGES, 2: number of flip-flop synchroniser stages on each sensor input (≥2).
- FILTER_LEN, 4: consecutive cycles a new synchronised pair must be stable before it is accepted (≥1).
- STILL_TIMEOUT, 1024: cycles without an accepted step before direction reports still (≥2).
- SATURATE, 0: counter overflow mode. 0 = two's-complement wrap; 1 = clamp at the signed min/max.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- sensor1_data, input, 1: raw sensor A (asynchronous to clk).
- sensor2_data, input, 1: raw sensor B (asynchronous to clk).
- clear, input, 1: synchronous clear of position and error.
- direction, output, 2: 11 = clockwise, 00 = anticlockwise, 01 = still, 10 = unknown/error.
- position, output, CNT_W: signed step count; clockwise is positive.
- step_valid, output, 1: one-cycle pulse on every accepted legal step.
- error, output, 1: sticky flag set by an illegal double-bit transition.

Behaviour:
- Reset (reset=0, asynchronous): direction=10, position=0, step_valid=0, error=0.
  - Synchronisers, filter, idle counter and reference register are cleared.
  - FSM enters INIT.
  - Reset asserted mid-operation aborts everything immediately; no partial step is committed.
- Input path:
  - Each sensor passes through SYNC_STAGES flops; the synchronised pair is s = {s2, s1}.
  - Filter: a candidate value different from the accepted value is accepted once s has equalled it for FILTER_LEN consecutive cycles.
  - Any change in s restarts the filter count.
  - Pulses shorter than FILTER_LEN cycles are never seen downstream.
- Latency: step_valid and the position/direction update occur exactly SYNC_STAGES+FILTER_LEN+1 rising edges after the first edge that samples the new raw value.
- FSM states:
  - INIT: the first accepted pair is loaded into the reference register. direction becomes 01; no step, no count. Go to TRACK.
  - TRACK: compare each accepted pair (new) with the reference (ref). Clockwise sequence is 00→01→11→10→00; anticlockwise is the reverse.
    - Clockwise step: position += 1, direction = 11, step_valid = 1, idle counter = 0.
    - Anticlockwise step: position -= 1, direction = 00, step_valid = 1, idle counter = 0.
    - Double-bit change (00↔11 or 01↔10): error = 1 (sticky), direction = 10, position unchanged, no step_valid, idle counter = 0.
    - In every case ref = new, so tracking resumes from the new pair.
- Still detection:
  - The idle counter increments every cycle in TRACK with no accepted change, saturating at STILL_TIMEOUT.
  - On reaching STILL_TIMEOUT, direction = 01.
  - Until then the last direction is held, including 10 after an error.
- Counter arithmetic:
  - SATURATE=0: wraps; max+1 → min, min-1 → max.
  - SATURATE=1: clamps at max/min. step_valid still pulses and direction still updates when clamped.
- clear=1:
  - Next edge sets position = 0 and error = 0.
  - direction, ref and FSM state are unaffected.
  - clear in the same cycle as a step: clear wins, so position = 0. step_valid and direction still reflect the step.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then hold {s2,s1}=00: direction=10 until the first accepted sample. Then direction=01 and position=0 with no step_valid.
- Drive 00→01→11→10→00, each held 20 cycles (defaults): four step_valid pulses, position=4, direction=11. Each update lands 7 edges after the input change. Then reverse the sequence: position returns to 0, direction=00.
- Glitch 3 cycles long on sensor1 (FILTER_LEN=4): no step_valid, position unchanged. A 4-cycle pulse produces a +1 step, then a -1 step.
- Jump 01→10: error=1, direction=10, position unchanged. A subsequent 10→00 gives position +1 and direction=11 while error stays 1. Pulse clear: position=0, error=0.
- No steps after a clockwise move: direction stays 11 for STILL_TIMEOUT-1 cycles, then becomes 01 (STILL_TIMEOUT=1024).
- CNT_W=4:
  - SATURATE=0: 8 clockwise steps from 0 give position=-8.
  - SATURATE=1: 10 steps give position=7, with 10 step_valid pulses.
  - Assert reset mid-sequence: all outputs return to reset values at once.
